// File: rtl/usb_crc_pkt_tx.sv
// USB packet transmit front-end.
// Serialises PID + body LSB-first and appends the complemented CRC
// (CRC5 for tokens, CRC16 for data). Handshakes go out PID-only.
// Serial output handshake: a bit moves only when bit_valid && bit_ready
// are both high on a rising clock edge. bit_out, bit_last and bit_valid
// hold while the consumer stalls, and bit_valid never drops inside a packet.
module usb_crc_pkt_tx #(
   parameter int MAX_DATA_BYTES = 8,
   parameter int LEN_W          = $clog2(MAX_DATA_BYTES + 1)
) (
   input  logic                        clk,
   input  logic                        rst_b,
   input  logic                        start,
   input  logic [1:0]                  mode,
   input  logic [7:0]                  pid,
   input  logic [8*MAX_DATA_BYTES-1:0] body,
   input  logic [LEN_W-1:0]            body_len,
   output logic                        ready_in,
   output logic                        bit_out,
   output logic                        bit_valid,
   input  logic                        bit_ready,
   output logic                        bit_last,
   output logic                        err
);

   localparam int BODY_W = 8 * MAX_DATA_BYTES;
   // Sized so the longest legal packet never wraps the counter.
   localparam int CNT_W  = $clog2(8 * MAX_DATA_BYTES + 16 + 1);

   // Packet classes carried in mode.
   localparam logic [1:0] MODE_HS   = 2'b00;
   localparam logic [1:0] MODE_TOK  = 2'b01;
   localparam logic [1:0] MODE_DATA = 2'b10;

   // FSM encoding.
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_PID  = 2'd1;
   localparam logic [1:0] S_BODY = 2'd2;
   localparam logic [1:0] S_CRC  = 2'd3;

   // Counter reload values: each holds "bits remaining in this field - 1".
   localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_PID_LAST = CNT_W'(7);
   localparam logic [CNT_W-1:0] CNT_TOK_LAST = CNT_W'(10);
   localparam logic [CNT_W-1:0] CNT_C5_LAST  = CNT_W'(4);
   localparam logic [CNT_W-1:0] CNT_C16_LAST = CNT_W'(15);

   // CRC generator polynomials (implicit top bit dropped).
   localparam logic [4:0]  POLY5  = 5'h05;
   localparam logic [15:0] POLY16 = 16'h8005;

   logic [1:0]        state;
   logic [CNT_W-1:0]  cnt;
   logic [7:0]        pid_sr;
   logic [BODY_W-1:0] body_sr;
   logic [1:0]        mode_q;
   logic [LEN_W-1:0]  len_q;
   logic [15:0]       crc;
   logic              err_q;

   logic              xfer;
   logic              req_illegal;
   logic              cnt_zero;
   logic [CNT_W-1:0]  data_bits_m1;
   logic              fb5;
   logic              fb16;
   logic [4:0]        crc5_n;
   logic [15:0]       crc16_n;

   // Handshake and request qualification.
   always_comb begin
      xfer        = 1'b0;
      req_illegal = 1'b0;
      cnt_zero    = 1'b0;
      xfer        = bit_valid & bit_ready;
      req_illegal = (mode == 2'b11) ||
                    ((mode == MODE_DATA) && (body_len > LEN_W'(MAX_DATA_BYTES)));
      cnt_zero    = (cnt == '0);
   end

   // Body bit count minus one for a data packet, from the latched length.
   always_comb begin
      data_bits_m1 = '0;
      data_bits_m1 = CNT_W'({len_q, 3'b000}) - CNT_ONE;
   end

   // Next CRC values for the body bit currently on the wire.
   always_comb begin
      fb5     = 1'b0;
      fb16    = 1'b0;
      crc5_n  = '0;
      crc16_n = '0;
      fb5     = crc[4] ^ body_sr[0];
      fb16    = crc[15] ^ body_sr[0];
      crc5_n  = {crc[3:0], 1'b0} ^ (fb5 ? POLY5 : 5'h00);
      crc16_n = {crc[14:0], 1'b0} ^ (fb16 ? POLY16 : 16'h0000);
   end

   // Serial output mux; everything derives from registers so it holds on stall.
   always_comb begin
      bit_out   = 1'b0;
      bit_last  = 1'b0;
      bit_valid = 1'b0;
      ready_in  = 1'b0;
      err       = err_q;
      case (state)
         S_IDLE: begin
            ready_in = 1'b1;
         end
         S_PID: begin
            bit_valid = 1'b1;
            bit_out   = pid_sr[0];
            bit_last  = cnt_zero && (mode_q == MODE_HS);
         end
         S_BODY: begin
            bit_valid = 1'b1;
            bit_out   = body_sr[0];
         end
         S_CRC: begin
            bit_valid = 1'b1;
            // Complemented CRC, MSB first; cnt walks the bit index down.
            bit_out   = ~crc[cnt[3:0]];
            bit_last  = cnt_zero;
         end
         default: begin
            ready_in = 1'b0;
         end
      endcase
   end

   // FSM state and per-field bit counter.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state <= S_IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start && !req_illegal) begin
                  state <= S_PID;
                  cnt   <= CNT_PID_LAST;
               end
            end
            S_PID: begin
               if (xfer) begin
                  if (cnt_zero) begin
                     case (mode_q)
                        MODE_TOK: begin
                           state <= S_BODY;
                           cnt   <= CNT_TOK_LAST;
                        end
                        MODE_DATA: begin
                           if (len_q == '0) begin
                              // Empty payload: CRC of nothing is ~16'hFFFF.
                              state <= S_CRC;
                              cnt   <= CNT_C16_LAST;
                           end else begin
                              state <= S_BODY;
                              cnt   <= data_bits_m1;
                           end
                        end
                        default: begin
                           state <= S_IDLE;
                           cnt   <= '0;
                        end
                     endcase
                  end else begin
                     cnt <= cnt - CNT_ONE;
                  end
               end
            end
            S_BODY: begin
               if (xfer) begin
                  if (cnt_zero) begin
                     state <= S_CRC;
                     cnt   <= (mode_q == MODE_TOK) ? CNT_C5_LAST : CNT_C16_LAST;
                  end else begin
                     cnt <= cnt - CNT_ONE;
                  end
               end
            end
            S_CRC: begin
               if (xfer) begin
                  if (cnt_zero) begin
                     state <= S_IDLE;
                  end else begin
                     cnt <= cnt - CNT_ONE;
                  end
               end
            end
            default: begin
               state <= S_IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

   // Request latch and PID/body shift registers.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         pid_sr  <= '0;
         body_sr <= '0;
         mode_q  <= MODE_HS;
         len_q   <= '0;
      end else begin
         if ((state == S_IDLE) && start && !req_illegal) begin
            pid_sr  <= pid;
            body_sr <= body;
            mode_q  <= mode;
            len_q   <= body_len;
         end else if (xfer && (state == S_PID)) begin
            pid_sr <= pid_sr >> 1;
         end else if (xfer && (state == S_BODY)) begin
            body_sr <= body_sr >> 1;
         end
      end
   end

   // CRC register: seeded at accept, advanced per body bit, frozen in CRC state.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         crc <= 16'hFFFF;
      end else begin
         if ((state == S_IDLE) && start && !req_illegal) begin
            // Tokens use the low five bits only; the rest stay zero.
            crc <= (mode == MODE_TOK) ? 16'h001F : 16'hFFFF;
         end else if (xfer && (state == S_BODY)) begin
            crc <= (mode_q == MODE_TOK) ? {11'b0, crc5_n} : crc16_n;
         end
      end
   end

   // One-cycle error pulse for a rejected request seen while idle.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         err_q <= 1'b0;
      end else begin
         err_q <= (state == S_IDLE) && start && req_illegal;
      end
   end

endmodule

// File: tb/tb_usb_crc_pkt_tx.sv
// Bench for usb_crc_pkt_tx: table of packets with expected serial images,
// plus hand-written sequences for rejects, busy starts and mid-packet reset.
module tb_usb_crc_pkt_tx;

   localparam int MAXB   = 8;
   localparam int LEN_W  = $clog2(MAXB + 1);
   localparam int BODY_W = 8 * MAXB;
   localparam int NVEC   = 9;

   // ---------------- clock / reset ----------------
   logic              clk;
   logic              rst_b;
   logic              start;
   logic [1:0]        mode;
   logic [7:0]        pid;
   logic [BODY_W-1:0] body;
   logic [LEN_W-1:0]  body_len;
   logic              ready_in;
   logic              bit_out;
   logic              bit_valid;
   logic              bit_ready;
   logic              bit_last;
   logic              err;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   usb_crc_pkt_tx #(.MAX_DATA_BYTES(MAXB)) dut (
      .clk       (clk),
      .rst_b     (rst_b),
      .start     (start),
      .mode      (mode),
      .pid       (pid),
      .body      (body),
      .body_len  (body_len),
      .ready_in  (ready_in),
      .bit_out   (bit_out),
      .bit_valid (bit_valid),
      .bit_ready (bit_ready),
      .bit_last  (bit_last),
      .err       (err)
   );

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard counters ----------------
   int n_pass  = 0;
   int n_total = 0;

   task automatic check(input string name, input logic [127:0] got,
                        input logic [127:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask

   // ---------------- reference model ----------------
   // Bit i of bits is the i-th serial bit on the wire.
   function automatic void ref_pkt(input logic [1:0] m, input logic [7:0] p,
                                   input logic [BODY_W-1:0] b,
                                   input logic [LEN_W-1:0] l,
                                   output logic [127:0] bits, output int n);
      logic [4:0]  c5;
      logic [15:0] c16;
      logic        fb;
      bits = '0;
      n    = 0;
      c5   = 5'h1F;
      c16  = 16'hFFFF;
      for (int i = 0; i < 8; i++) begin
         bits[n] = p[i];
         n++;
      end
      if (m == 2'b01) begin
         for (int i = 0; i < 11; i++) begin
            bits[n] = b[i];
            fb = c5[4] ^ b[i];
            c5 = {c5[3:0], 1'b0} ^ (fb ? 5'h05 : 5'h00);
            n++;
         end
         for (int i = 4; i >= 0; i--) begin
            bits[n] = ~c5[i];
            n++;
         end
      end else if (m == 2'b10) begin
         for (int i = 0; i < 8 * int'(l); i++) begin
            bits[n] = b[i];
            fb  = c16[15] ^ b[i];
            c16 = {c16[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
            n++;
         end
         for (int i = 15; i >= 0; i--) begin
            bits[n] = ~c16[i];
            n++;
         end
      end
   endfunction

   // CRC run over everything after the PID, appended CRC included.
   function automatic logic [15:0] residual(input logic [1:0] m,
                                            input logic [127:0] bits,
                                            input int n);
      logic [4:0]  c5;
      logic [15:0] c16;
      logic        fb;
      c5  = 5'h1F;
      c16 = 16'hFFFF;
      for (int i = 8; i < n; i++) begin
         fb  = c5[4] ^ bits[i];
         c5  = {c5[3:0], 1'b0} ^ (fb ? 5'h05 : 5'h00);
         fb  = c16[15] ^ bits[i];
         c16 = {c16[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
      end
      return (m == 2'b01) ? {11'b0, c5} : c16;
   endfunction

   // ---------------- driver tasks ----------------
   // Entered and left at 1 time unit after a rising edge with the DUT idle.
   task automatic send_pkt(input logic [1:0] m, input logic [7:0] p,
                           input logic [BODY_W-1:0] b,
                           input logic [LEN_W-1:0] l, input int stall,
                           input logic busy, output logic [127:0] rx,
                           output int n);
      logic done, gap, err_seen, prev_stall, prev_out, prev_last;
      start     = 1'b1;
      mode      = m;
      pid       = p;
      body      = b;
      body_len  = l;
      bit_ready = 1'b0;
      @(posedge clk); #1;
      start = busy;
      if (busy) mode = 2'b11;
      check("first_bit_latency", {31'b0, bit_valid}, 32'd1);
      rx = '0;
      n = 0;
      done = 1'b0;
      gap = 1'b0;
      err_seen = 1'b0;
      prev_stall = 1'b0;
      prev_out = 1'b0;
      prev_last = 1'b0;
      for (int cyc = 0; cyc < 2000 && !done; cyc++) begin
         if (err) err_seen = 1'b1;
         if (!bit_valid) begin
            gap = 1'b1;
            break;
         end
         if (prev_stall)
            check("stall_hold", {126'b0, bit_out, bit_last},
                  {126'b0, prev_out, prev_last});
         bit_ready = ($urandom_range(0, 99) >= stall);
         if (bit_ready && n < 128) begin
            rx[n] = bit_out;
            n++;
            if (bit_last) begin
               done  = 1'b1;
               start = 1'b0;
            end
         end
         prev_stall = !bit_ready;
         prev_out   = bit_out;
         prev_last  = bit_last;
         @(posedge clk); #1;
      end
      start     = 1'b0;
      bit_ready = 1'b0;
      check("no_valid_gap", {127'b0, gap}, 128'd0);
      check("packet_done", {127'b0, done}, 128'd1);
      check("idle_after_pkt", {126'b0, ready_in, bit_valid}, 128'b10);
      if (busy) check("busy_start_no_err", {127'b0, err_seen}, 128'd0);
   endtask

   task automatic send_illegal(input string name, input logic [1:0] m,
                               input logic [LEN_W-1:0] l);
      start    = 1'b1;
      mode     = m;
      body_len = l;
      @(posedge clk); #1;
      start = 1'b0;
      check({name, "_err"}, {125'b0, err, bit_valid, ready_in}, 128'b101);
      @(posedge clk); #1;
      check({name, "_after"}, {125'b0, err, bit_valid, ready_in}, 128'b001);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      string             name;
      logic [1:0]        m;
      logic [7:0]        p;
      logic [BODY_W-1:0] b;
      logic [LEN_W-1:0]  l;
      int                stall;
      int                exp_len;
      logic [127:0]      exp_bits;
   } vec_t;

   vec_t vecs[NVEC];

   task automatic set_model_vec(input int k, input string nm, input logic [1:0] m,
                                input logic [7:0] p, input logic [BODY_W-1:0] b,
                                input logic [LEN_W-1:0] l, input int stall);
      logic [127:0] eb;
      int           el;
      ref_pkt(m, p, b, l, eb, el);
      vecs[k] = '{nm, m, p, b, l, stall, el, eb};
   endtask

   logic [127:0] rx;
   int           n;
   logic [127:0] eb;
   int           el;

   initial begin
      rst_b     = 1'b0;
      start     = 1'b0;
      mode      = 2'b00;
      pid       = 8'h00;
      body      = '0;
      body_len  = '0;
      bit_ready = 1'b0;

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs", {123'b0, ready_in, bit_valid, bit_out, bit_last, err},
            128'b10000);
      rst_b = 1'b1;
      @(posedge clk); #1;
      check("idle_outputs", {123'b0, ready_in, bit_valid, bit_out, bit_last, err},
            128'b10000);

      // Hand-computed images, then model-derived ones.
      vecs[0] = '{"ack_handshake", 2'b00, 8'hD2, '0, '0, 0, 8, 128'hD2};
      vecs[1] = '{"setup_token", 2'b01, 8'h2D, '0, '0, 0, 24, 128'h10002D};
      vecs[2] = '{"data0_empty", 2'b10, 8'hC3, '0, '0, 0, 24, 128'h0000C3};
      vecs[3] = '{"setup_token_stall", 2'b01, 8'h2D, '0, '0, 40, 24, 128'h10002D};
      set_model_vec(4, "in_token_rand", 2'b01, 8'h69,
                    BODY_W'($urandom_range(0, 2047)), '0, 30);
      set_model_vec(5, "data_len1", 2'b10, 8'hC3, {$urandom, $urandom}, 4'd1, 30);
      set_model_vec(6, "data_len3", 2'b10, 8'h4B, {$urandom, $urandom}, 4'd3, 50);
      set_model_vec(7, "data_len_max", 2'b10, 8'hC3, {$urandom, $urandom},
                    LEN_W'(MAXB), 25);
      set_model_vec(8, "data_len_rand", 2'b10, 8'h4B, {$urandom, $urandom},
                    LEN_W'($urandom_range(1, MAXB)), 35);

      for (int k = 0; k < NVEC; k++) begin
         send_pkt(vecs[k].m, vecs[k].p, vecs[k].b, vecs[k].l, vecs[k].stall,
                  1'b0, rx, n);
         check({vecs[k].name, "_len"}, 128'(n), 128'(vecs[k].exp_len));
         check({vecs[k].name, "_bits"}, rx, vecs[k].exp_bits);
         if (vecs[k].m == 2'b01)
            check({vecs[k].name, "_resid5"}, {112'b0, residual(2'b01, rx, n)},
                  128'h0C);
         if (vecs[k].m == 2'b10)
            check({vecs[k].name, "_resid16"}, {112'b0, residual(2'b10, rx, n)},
                  128'h800D);
      end

      // Rejected requests.
      send_illegal("reserved_mode", 2'b11, 4'd0);
      send_illegal("data_too_long", 2'b10, LEN_W'(MAXB + 1));

      // Start held high (reserved mode) through a packet: ignored, no err.
      body = {$urandom, $urandom};
      ref_pkt(2'b10, 8'hC3, body, 4'd2, eb, el);
      send_pkt(2'b10, 8'hC3, body, 4'd2, 20, 1'b1, rx, n);
      check("busy_pkt_len", 128'(n), 128'(el));
      check("busy_pkt_bits", rx, eb);

      // Reset dropped after 10 bits of a data packet.
      start     = 1'b1;
      mode      = 2'b10;
      pid       = 8'hC3;
      body      = {$urandom, $urandom};
      body_len  = 4'd4;
      bit_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check("pre_reset_busy", {127'b0, bit_valid}, 128'd1);
      rst_b = 1'b0;
      #1;
      check("midpkt_reset_abort", {124'b0, bit_valid, ready_in, bit_out, bit_last},
            128'b0100);
      @(posedge clk); #1;
      check("midpkt_reset_hold", {126'b0, bit_valid, ready_in}, 128'b01);
      rst_b     = 1'b1;
      bit_ready = 1'b0;
      @(posedge clk); #1;
      send_pkt(2'b01, 8'h2D, '0, '0, 0, 1'b0, rx, n);
      check("setup_after_reset_len", 128'(n), 128'd24);
      check("setup_after_reset_bits", rx, 128'h10002D);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
